// File: rtl/isqrt_iter_fsm.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_iter_fsm
// Description : Iterative integer square root, y = floor(sqrt(x)).
//               Uses the digit-by-digit shift/subtract recurrence and produces
//               one result bit per clock, so a result takes N/2 cycles.
//               A new argument is accepted in the same cycle a result is
//               presented, so requests can be chained without a dead cycle.
//               N must be even and at least 4.
//               Optional macro ISQRT_ITER_X_RDY_EN adds the x_rdy output,
//               which is high while the unit is idle and can take x_vld.
// Revision    : 1.0 - initial release
// ============================================================================
module isqrt_iter_fsm #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst,      // synchronous, active-low
    input  logic           x_vld,
    input  logic [N-1:0]   x,
    output logic           y_vld,
    output logic [N/2-1:0] y
`ifdef ISQRT_ITER_X_RDY_EN
    ,
    output logic           x_rdy
`endif
);

    // Iteration counter counts N/2-1 down to 0
    localparam int CW = (N / 2 > 1) ? $clog2(N / 2) : 1;

    localparam logic [0:0]    S_IDLE = 1'b0;
    localparam logic [0:0]    S_CALC = 1'b1;

    localparam logic [CW-1:0] C_CNT_INIT = CW'(N / 2 - 1);
    localparam logic [N-1:0]  C_BIT_INIT = {2'b01, {(N - 2){1'b0}}};

    logic [0:0]     state_q, state_d;
    logic [N-1:0]   rem_q,   rem_d;
    logic [N-1:0]   root_q,  root_d;
    logic [N-1:0]   bit_q,   bit_d;
    logic [CW-1:0]  cnt_q,   cnt_d;
    logic [N/2-1:0] y_q,     y_d;
    logic           y_vld_q, y_vld_d;

    logic [N-1:0]   w_trial;
    logic           w_take;
    logic [N-1:0]   w_root_nx;
    logic [N-1:0]   w_rem_nx;

    // State and datapath registers; reset clears everything and aborts any run
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            root_q  <= '0;
            bit_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            y_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            root_q  <= root_d;
            bit_q   <= bit_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            y_vld_q <= y_vld_d;
        end
    end

    // Next-state logic: leave IDLE on a request, return after the last iteration
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (x_vld) begin
                    state_d = S_CALC;
                end
            end
            S_CALC: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One recurrence step: subtract the trial value when it fits in the remainder
    always_comb begin
        w_trial   = root_q + bit_q;
        w_take    = (rem_q >= w_trial);
        w_root_nx = w_take ? ((root_q >> 1) + bit_q) : (root_q >> 1);
        w_rem_nx  = w_take ? (rem_q - w_trial) : rem_q;
    end

    // Datapath and output next values; x_vld during CALC is simply ignored
    always_comb begin
        rem_d   = rem_q;
        root_d  = root_q;
        bit_d   = bit_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        y_vld_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (x_vld) begin
                    rem_d  = x;
                    root_d = '0;
                    bit_d  = C_BIT_INIT;
                    cnt_d  = C_CNT_INIT;
                end
            end
            S_CALC: begin
                rem_d  = w_rem_nx;
                root_d = w_root_nx;
                bit_d  = bit_q >> 2;
                if (cnt_q == '0) begin
                    y_d     = w_root_nx[N/2-1:0];
                    y_vld_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                rem_d = '0;
            end
        endcase
    end

    assign y_vld = y_vld_q;
    assign y     = y_q;

`ifdef ISQRT_ITER_X_RDY_EN
    // Ready while idle; forced low whenever reset is being applied
    assign x_rdy = rst && (state_q == S_IDLE);
`endif

endmodule
`default_nettype wire
